xlnx_mmcm_drp_seq: RTL and testbench

MMCM dynamic-reconfiguration sequencer, in the startup/clocking domain on `cfg_mclk`. On a start request it holds the MMCM in reset and walks a per-profile register table (profile 0 = PCIe, 1 = USB2). For each entry it does a DRP read-modify-write, then releases reset and waits for lock, retrying on lock timeout. Startup mode selection drives it, so the PIPE MMCM can be retuned when the link falls back from PCIe to USB2.

---
 rtl/xlnx_mmcm_drp_seq_if.sv | 46 ++++
 rtl/xlnx_mmcm_drp_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_xlnx_mmcm_drp_seq.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xlnx_mmcm_drp_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : xlnx_mmcm_drp_seq_if
//  Description : Bundle of the control, table-ROM, DRP and MMCM signals of the
//                MMCM dynamic-reconfiguration sequencer.
//                slave  : sequencer side (drives tbl_idx, DRP request, mmcm_rst,
//                         status).
//                master : environment side (start/profile, ROM data, DRP
//                         response, MMCM lock).
//  Revision    : 1.0 - initial release
// ============================================================================
interface xlnx_mmcm_drp_seq_if #(
  parameter int NREGS = 8
) ();
  localparam int c_idx_w = 1 + $clog2(NREGS);

  logic               start;
  logic               profile_sel;
  logic [c_idx_w-1:0] tbl_idx;
  logic [38:0]        tbl_entry;
  logic               drp_en;
  logic               drp_we;
  logic [6:0]         drp_addr;
  logic [15:0]        drp_di;
  logic [15:0]        drp_do;
  logic               drp_rdy;
  logic               mmcm_rst;
  logic               mmcm_locked;
  logic               busy;
  logic               done;
  logic               error;
  logic [3:0]         dbg_state;

  modport slave (
    input  start, profile_sel, tbl_entry, drp_do, drp_rdy, mmcm_locked,
    output tbl_idx, drp_en, drp_we, drp_addr, drp_di, mmcm_rst,
           busy, done, error, dbg_state
  );

  modport master (
    output start, profile_sel, tbl_entry, drp_do, drp_rdy, mmcm_locked,
    input  tbl_idx, drp_en, drp_we, drp_addr, drp_di, mmcm_rst,
           busy, done, error, dbg_state
  );
endinterface
`default_nettype wire

// File: rtl/xlnx_mmcm_drp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : xlnx_mmcm_drp_seq
//  Description : MMCM dynamic-reconfiguration sequencer. On start it holds the
//                MMCM in reset, read-modify-writes every DRP register listed in
//                the selected profile table (0 = PCIe, 1 = USB2), releases
//                reset and waits for lock, rewriting the whole table on a lock
//                timeout up to MAX_RETRY times.
//  Ports       : cfg_mclk - only clock
//                rst      - asynchronous active-high reset
//                bus      - xlnx_mmcm_drp_seq_if.slave: start/profile_sel in,
//                           table ROM (tbl_idx out, tbl_entry in), DRP port,
//                           mmcm_rst out / mmcm_locked in, busy/done/error,
//                           dbg_state
//  Revision    : 1.0 - initial release
// ============================================================================
module xlnx_mmcm_drp_seq #(
  parameter int NREGS     = 8,
  parameter int TMO_BITS  = 16,
  parameter int MAX_RETRY = 3
) (
  input wire cfg_mclk,
  input wire rst,
  xlnx_mmcm_drp_seq_if.slave bus
);

  localparam int c_ent_w = $clog2(NREGS);
  localparam int c_idx_w = c_ent_w + 1;
  localparam logic [c_ent_w-1:0]  c_last_entry = c_ent_w'(NREGS - 1);
  localparam logic [c_ent_w-1:0]  c_first_entry = '0;
  // One below all-ones: the wait ends on the cycle the count would reach
  // all-ones, so a wait lasts exactly 2^TMO_BITS-1 cycles.
  localparam logic [TMO_BITS-1:0] c_tmo_pre = {{(TMO_BITS-1){1'b1}}, 1'b0};
  localparam logic [2:0]          c_max_retry = 3'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RST_ON    = 4'd1,
    S_FETCH     = 4'd2,
    S_RD_REQ    = 4'd3,
    S_RD_WAIT   = 4'd4,
    S_WR_REQ    = 4'd5,
    S_WR_WAIT   = 4'd6,
    S_NEXT      = 4'd7,
    S_RST_OFF   = 4'd8,
    S_WAIT_LOCK = 4'd9,
    S_DONE      = 4'd10,
    S_ERR       = 4'd11
  } state_t;

  state_t              r_state;
  logic                r_profile;
  logic [c_ent_w-1:0]  r_entry;
  logic [2:0]          r_retry;
  logic [TMO_BITS-1:0] r_tmo;
  logic [1:0]          r_lock_cnt;
  logic [1:0]          r_lock_sync;
  logic [15:0]         r_mask;
  logic [15:0]         r_data;
  logic [c_idx_w-1:0]  r_tbl_idx;
  logic                r_drp_en;
  logic                r_drp_we;
  logic [6:0]          r_drp_addr;
  logic [15:0]         r_drp_di;
  logic                r_mmcm_rst;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic                w_lock;
  logic                w_tmo_fire;
  logic [TMO_BITS-1:0] w_tmo_inc;
  logic [15:0]         w_wr_data;

  assign w_lock     = r_lock_sync[1];
  assign w_tmo_fire = (r_tmo >= c_tmo_pre);
  assign w_tmo_inc  = (&r_tmo) ? r_tmo : r_tmo + 1'b1;
  // Keep-mask bits come from the current register value, the rest from table.
  assign w_wr_data  = (bus.drp_do & r_mask) | (r_data & ~r_mask);

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge cfg_mclk or posedge rst) begin
    if (rst) begin
      r_lock_sync <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], bus.mmcm_locked};
    end
  end

  always_ff @(posedge cfg_mclk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_profile  <= 1'b0;
      r_entry    <= '0;
      r_retry    <= 3'd0;
      r_tmo      <= '0;
      r_lock_cnt <= 2'd0;
      r_mask     <= 16'h0000;
      r_data     <= 16'h0000;
      r_tbl_idx  <= '0;
      r_drp_en   <= 1'b0;
      r_drp_we   <= 1'b0;
      r_drp_addr <= 7'h00;
      r_drp_di   <= 16'h0000;
      r_mmcm_rst <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      // DRP enable/write-enable are single-cycle strobes.
      r_drp_en <= 1'b0;
      r_drp_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_profile  <= bus.profile_sel;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_entry    <= '0;
            r_retry    <= 3'd0;
            r_mmcm_rst <= 1'b1;
            r_tbl_idx  <= {bus.profile_sel, c_first_entry};
            r_busy     <= 1'b1;
            r_state    <= S_RST_ON;
          end
        end
        // The RST_ON cycle covers the ROM latency for entry 0.
        S_RST_ON: r_state <= S_FETCH;
        S_FETCH: begin
          r_drp_addr <= bus.tbl_entry[38:32];
          r_mask     <= bus.tbl_entry[31:16];
          r_data     <= bus.tbl_entry[15:0];
          r_drp_en   <= 1'b1;
          r_state    <= S_RD_REQ;
        end
        S_RD_REQ: begin
          r_tmo   <= '0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (bus.drp_rdy) begin
            r_drp_di <= w_wr_data;
            r_drp_en <= 1'b1;
            r_drp_we <= 1'b1;
            r_state  <= S_WR_REQ;
          end else if (w_tmo_fire) begin
            r_error    <= 1'b1;
            r_mmcm_rst <= 1'b1;
            r_state    <= S_ERR;
          end else begin
            r_tmo <= w_tmo_inc;
          end
        end
        S_WR_REQ: begin
          r_tmo   <= '0;
          r_state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (bus.drp_rdy) begin
            // Advance the ROM address already here so the next entry's data
            // is valid by the time FETCH samples it.
            if (r_entry != c_last_entry) begin
              r_tbl_idx <= {r_profile, r_entry + 1'b1};
            end
            r_state <= S_NEXT;
          end else if (w_tmo_fire) begin
            r_error    <= 1'b1;
            r_mmcm_rst <= 1'b1;
            r_state    <= S_ERR;
          end else begin
            r_tmo <= w_tmo_inc;
          end
        end
        S_NEXT: begin
          if (r_entry == c_last_entry) begin
            r_mmcm_rst <= 1'b0;
            r_tmo      <= '0;
            r_lock_cnt <= 2'd0;
            r_state    <= S_RST_OFF;
          end else begin
            r_entry <= r_entry + 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_RST_OFF: r_state <= S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (w_lock && (r_lock_cnt == 2'd3)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_tmo_fire) begin
            r_mmcm_rst <= 1'b1;
            if (r_retry < c_max_retry) begin
              r_retry   <= r_retry + 3'd1;
              r_entry   <= '0;
              r_tbl_idx <= {r_profile, c_first_entry};
              r_state   <= S_RST_ON;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERR;
            end
          end else begin
            r_tmo      <= w_tmo_inc;
            r_lock_cnt <= w_lock ? (r_lock_cnt + 2'd1) : 2'd0;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        // mmcm_rst was raised on the way in and stays up until a later run
        // reaches RST_OFF.
        S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tbl_idx   = r_tbl_idx;
  assign bus.drp_en    = r_drp_en;
  assign bus.drp_we    = r_drp_we;
  assign bus.drp_addr  = r_drp_addr;
  assign bus.drp_di    = r_drp_di;
  assign bus.mmcm_rst  = r_mmcm_rst;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.dbg_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_xlnx_mmcm_drp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xlnx_mmcm_drp_seq
//  Description : Self-checking bench for xlnx_mmcm_drp_seq (NREGS=8,
//                TMO_BITS=8, MAX_RETRY=3) with a registered table ROM, a DRP
//                responder and an MMCM lock model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xlnx_mmcm_drp_seq;

  logic clk;
  logic rst;
  int   cyc;

  xlnx_mmcm_drp_seq_if #(.NREGS(8)) bus ();

  xlnx_mmcm_drp_seq #(
    .NREGS    (8),
    .TMO_BITS (8),
    .MAX_RETRY(3)
  ) dut (
    .cfg_mclk(clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Table ROM: profile 1 = mask 00FF / data 1234, profile 0 = mask F0F0 / data ABCD
  function automatic logic [38:0] rom_word(input logic [3:0] idx);
    logic [6:0] a;
    a = idx[3] ? (7'h40 + 7'(idx[2:0])) : (7'h10 + 7'(idx[2:0]));
    return idx[3] ? {a, 16'h00FF, 16'h1234} : {a, 16'hF0F0, 16'hABCD};
  endfunction

  always @(posedge clk) bus.tbl_entry <= rom_word(bus.tbl_idx);

  // MMCM lock model: follows the reset release, or is driven by hand.
  logic lock_follow;
  logic lock_man;
  assign bus.mmcm_locked = lock_follow ? ~bus.mmcm_rst : lock_man;

  // Scoreboard of expected DRP writes.
  typedef struct packed {
    logic [3:0]  idx;
    logic [6:0]  addr;
    logic [15:0] di;
  } exp_t;
  exp_t sb[$];

  task automatic push_pass(input logic prof, input logic [15:0] rd_val);
    logic [38:0] w;
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      w      = rom_word({prof, 3'(k)});
      e.idx  = {prof, 3'(k)};
      e.addr = w[38:32];
      e.di   = (rd_val & w[31:16]) | (w[15:0] & ~w[31:16]);
      sb.push_back(e);
    end
  endtask

  // DRP responder and write monitor.
  int   rdy_lat = 3;
  bit   no_rdy  = 0;
  int   wr_count = 0;
  int   done_rises = 0;
  initial begin
    int   cd;
    logic prev_en;
    logic prev_done;
    exp_t e;
    cd = 0; prev_en = 1'b0; prev_done = 1'b0;
    bus.drp_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cd = 0; prev_en = 1'b0; prev_done = 1'b0;
        bus.drp_rdy = 1'b0;
      end else begin
        bus.drp_rdy = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0 && !no_rdy) bus.drp_rdy = 1'b1;
        end
        if (bus.drp_en) begin
          check("drp_en_gap", prev_en, 1'b0);
          cd = rdy_lat;
          if (bus.drp_we) begin
            wr_count++;
            if (sb.size() == 0) begin
              check("unexpected_write", 1'b1, 1'b0);
            end else begin
              e = sb.pop_front();
              check("wr_tbl_idx", bus.tbl_idx, e.idx);
              check("wr_addr", bus.drp_addr, e.addr);
              check("wr_di", bus.drp_di, e.di);
              check("wr_mmcm_rst", bus.mmcm_rst, 1'b1);
            end
          end
        end
        if (bus.done && !prev_done) done_rises++;
        prev_en   = bus.drp_en;
        prev_done = bus.done;
      end
    end
  end

  task automatic do_start(input logic prof);
    @(negedge clk);
    bus.profile_sel = prof;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (bus.busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.busy, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_drp_en"},   bus.drp_en, 1'b0);
    check({tag, "_drp_we"},   bus.drp_we, 1'b0);
    check({tag, "_drp_addr"}, bus.drp_addr, 7'h00);
    check({tag, "_drp_di"},   bus.drp_di, 16'h0000);
    check({tag, "_tbl_idx"},  bus.tbl_idx, 4'h0);
    check({tag, "_mmcm_rst"}, bus.mmcm_rst, 1'b0);
    check({tag, "_busy"},     bus.busy, 1'b0);
    check({tag, "_done"},     bus.done, 1'b0);
    check({tag, "_error"},    bus.error, 1'b0);
    check({tag, "_state"},    bus.dbg_state, 4'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wr0;
    int dr0;
    int k_done;
    int en_cyc;
    int err_cyc;

    cyc = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.profile_sel = 1'b0;
    bus.drp_do = 16'hFFFF;
    lock_follow = 1'b1;
    lock_man = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // ---- 1: profile 1, rdy 3 cycles after en, ideal lock ----
    push_pass(1'b1, 16'hFFFF);
    wr0 = wr_count;
    do_start(1'b1);
    check("t1_busy_n1", bus.busy, 1'b1);
    check("t1_rst_n1", bus.mmcm_rst, 1'b1);
    check("t1_idx_n1", bus.tbl_idx, 4'd8);
    @(negedge clk);
    check("t1_en_n2", bus.drp_en, 1'b0);
    @(negedge clk);
    check("t1_en_n3", bus.drp_en, 1'b1);
    wait_idle("t1_idle", 600);
    check("t1_done", bus.done, 1'b1);
    check("t1_error", bus.error, 1'b0);
    check("t1_mmcm_rst", bus.mmcm_rst, 1'b0);
    check("t1_writes", wr_count - wr0, 8);
    check("t1_sb_empty", sb.size(), 0);

    // ---- 6: lock glitch (high 3, low 1, then high) ----
    lock_follow = 1'b0;
    lock_man = 1'b0;
    push_pass(1'b0, 16'hFFFF);
    wr0 = wr_count;
    do_start(1'b0);
    n = 0;
    while (bus.mmcm_rst && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("t6_rst_release", bus.mmcm_rst, 1'b0);
    lock_man = 1'b1;
    repeat (3) @(negedge clk);
    lock_man = 1'b0;
    @(negedge clk);
    check("t6_still_waiting", bus.dbg_state, 4'd9);
    lock_man = 1'b1;
    k_done = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k_done < 0 && bus.dbg_state == 4'd10) k_done = k;
    end
    // low sampled at edge 0; sync low through edge 2, highs on edges 3..6
    check("t6_done_latency", k_done, 6);
    wait_idle("t6_idle", 50);
    check("t6_done", bus.done, 1'b1);
    check("t6_writes_no_retry", wr_count - wr0, 8);
    lock_follow = 1'b1;

    // ---- 3: drp_rdy never asserted ----
    no_rdy = 1'b1;
    wr0 = wr_count;
    en_cyc = -1;
    err_cyc = -1;
    do_start(1'b1);
    for (int k = 0; k < 600; k++) begin
      if (bus.drp_en && en_cyc < 0) en_cyc = cyc;
      if (bus.dbg_state == 4'd11) begin
        err_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("t3_err_reached", (err_cyc >= 0), 1'b1);
    check("t3_rd_wait_cycles", err_cyc - en_cyc - 1, 255);
    wait_idle("t3_idle", 10);
    check("t3_error", bus.error, 1'b1);
    check("t3_done", bus.done, 1'b0);
    check("t3_mmcm_rst", bus.mmcm_rst, 1'b1);
    check("t3_no_writes", wr_count - wr0, 0);
    no_rdy = 1'b0;

    // ---- 4: start pulsed repeatedly while busy ----
    bus.drp_do = 16'h5A5A;
    push_pass(1'b0, 16'h5A5A);
    wr0 = wr_count;
    dr0 = done_rises;
    do_start(1'b0);
    n = 0;
    while (bus.busy && n < 800) begin
      @(negedge clk);
      n++;
      if ((n % 7) == 0 && bus.busy) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n++;
      end
    end
    check("t4_idle", bus.busy, 1'b0);
    repeat (10) @(negedge clk);
    check("t4_no_restart", bus.dbg_state, 4'd0);
    check("t4_single_done", done_rises - dr0, 1);
    check("t4_done", bus.done, 1'b1);
    check("t4_mmcm_rst_cleared", bus.mmcm_rst, 1'b0);
    check("t4_writes", wr_count - wr0, 8);
    check("t4_sb_empty", sb.size(), 0);
    bus.drp_do = 16'hFFFF;

    // ---- 2: lock never arrives ----
    lock_follow = 1'b0;
    lock_man = 1'b0;
    for (int p = 0; p < 4; p++) push_pass(1'b1, 16'hFFFF);
    wr0 = wr_count;
    do_start(1'b1);
    wait_idle("t2_idle", 3000);
    check("t2_writes", wr_count - wr0, 32);
    check("t2_error", bus.error, 1'b1);
    check("t2_done", bus.done, 1'b0);
    check("t2_mmcm_rst", bus.mmcm_rst, 1'b1);
    check("t2_sb_empty", sb.size(), 0);
    lock_follow = 1'b1;

    // ---- 5: reset during WR_WAIT of entry 3 ----
    push_pass(1'b1, 16'hFFFF);
    do_start(1'b1);
    n = 0;
    while (!(bus.dbg_state == 4'd6 && bus.tbl_idx == 4'd11) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_wr_wait3", bus.dbg_state, 4'd6);
    rst = 1'b1;
    #1;
    check_reset("t5_async");
    repeat (2) @(negedge clk);
    sb.delete();
    rst = 1'b0;
    push_pass(1'b1, 16'hFFFF);
    wr0 = wr_count;
    do_start(1'b1);
    check("t5_restart_idx", bus.tbl_idx, 4'd8);
    wait_idle("t5_idle", 600);
    check("t5_done", bus.done, 1'b1);
    check("t5_error", bus.error, 1'b0);
    check("t5_writes", wr_count - wr0, 8);
    check("t5_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
